// File: rtl/pipe_buf_pkg.sv
// Shared definitions for the handshaked inter-stage pipeline buffer:
// payload field widths, the derived payload width, NOP constant and FSM encodings.
package pipe_buf_pkg;

  localparam int unsigned PC_W       = 32;
  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned INT_W      = 1;
  localparam int unsigned DEF_DATA_W = PC_W + INSTR_W + IMM_W + INT_W;

  localparam logic [DEF_DATA_W-1:0] DEF_NOP_VALUE = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and synchronous clear to NOP_VALUE.
// Clear wins over load; updates on the falling clock edge like the rest of the pipeline.
module pipe_data_reg
  import pipe_buf_pkg::*;
#(
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_q;

  always_ff @(negedge clk) begin
    if (clear) begin
      data_q <= NOP_VALUE;
    end else if (load) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready skid buffer between pipeline stages, with synchronous flush.
// Main register is always the head; skid holds the second entry during a downstream stall.
module pipe_skid_buffer
  import pipe_buf_pkg::*;
#(
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  state_e            state_q;
  logic              clear;
  logic              accept;
  logic              drain;
  logic              main_load;
  logic              skid_load;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  // Handshake outputs decode registered state only; no path from out_ready to in_ready.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = out_valid ? main_q : NOP_VALUE;
  assign occupancy = state_q;

  assign clear  = reset | flush;
  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Main refills from skid when draining TWO, otherwise from the upstream payload.
  assign main_load = (state_q == ST_TWO) ? drain
                                         : (accept & ((state_q == ST_EMPTY) | drain));
  assign skid_load = (state_q == ST_ONE) & accept & ~drain;
  assign main_d    = (state_q == ST_TWO) ? skid_q : in_data;

  always_ff @(negedge clk) begin
    if (clear) begin
      state_q <= ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (accept) state_q <= ST_ONE;
        ST_ONE: begin
          if (drain && !accept) begin
            state_q <= ST_EMPTY;
          end else if (!drain && accept) begin
            state_q <= ST_TWO;
          end
        end
        ST_TWO:   if (drain) state_q <= ST_ONE;
        default:  state_q <= ST_EMPTY;
      endcase
    end
  end

  pipe_data_reg #(
    .DATA_W   (DATA_W),
    .NOP_VALUE(NOP_VALUE)
  ) u_main (
    .clk  (clk),
    .clear(clear),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  pipe_data_reg #(
    .DATA_W   (DATA_W),
    .NOP_VALUE(NOP_VALUE)
  ) u_skid (
    .clk  (clk),
    .clear(clear),
    .load (skid_load),
    .d    (in_data),
    .q    (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed and randomized checks of pipe_skid_buffer against hand-computed values
// and a small FIFO reference model.
module tb_pipe_skid_buffer;

  localparam int unsigned DW = 65;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int n_checks;
  int n_pass;

  // Packed view of all outputs: {in_ready, out_valid, occupancy, out_data}
  logic [DW+3:0] obs;
  logic [DW+3:0] exp_v;

  assign obs = {in_ready, out_valid, occupancy, out_data};

  pipe_skid_buffer #(
    .DATA_W(DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // State changes on the falling edge; sample and drive 1 time unit after it.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 65'h1_0000_0040_1234_ABCD;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = {1'b1, 1'b0, 2'd0, {DW{1'b0}}};
      n_checks++;
      if (obs !== exp_v) $display("FAIL reset[%0d]: got %h, want %h", i, obs, exp_v);
      else n_pass++;
    end
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_streaming();
    logic [DW-1:0] vals [3];
    vals[0] = 65'h11;
    vals[1] = 65'h22;
    vals[2] = 65'h33;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vals[i];
      tick();
      exp_v = {1'b1, 1'b1, 2'd1, vals[i]};
      n_checks++;
      if (obs !== exp_v) $display("FAIL stream[%0d]: got %h, want %h", i, obs, exp_v);
      else n_pass++;
    end
    in_valid = 1'b0;
    tick();
    exp_v = {1'b1, 1'b0, 2'd0, {DW{1'b0}}};
    n_checks++;
    if (obs !== exp_v) $display("FAIL stream_empty: got %h, want %h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_stall_skid();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 65'h11;
    tick();
    exp_v = {1'b1, 1'b1, 2'd1, 65'h11};
    n_checks++;
    if (obs !== exp_v) $display("FAIL skid_first: got %h, want %h", obs, exp_v);
    else n_pass++;

    out_ready = 1'b0;
    in_data   = 65'h22;
    tick();
    exp_v = {1'b0, 1'b1, 2'd2, 65'h11};
    n_checks++;
    if (obs !== exp_v) $display("FAIL skid_full: got %h, want %h", obs, exp_v);
    else n_pass++;

    in_data = 65'h33;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_v) $display("FAIL skid_hold[%0d]: got %h, want %h", i, obs, exp_v);
      else n_pass++;
    end

    out_ready = 1'b1;
    tick();
    exp_v = {1'b1, 1'b1, 2'd1, 65'h22};
    n_checks++;
    if (obs !== exp_v) $display("FAIL skid_drain1: got %h, want %h", obs, exp_v);
    else n_pass++;

    tick();
    exp_v = {1'b1, 1'b1, 2'd1, 65'h33};
    n_checks++;
    if (obs !== exp_v) $display("FAIL skid_drain2: got %h, want %h", obs, exp_v);
    else n_pass++;

    in_valid = 1'b0;
    tick();
    exp_v = {1'b1, 1'b0, 2'd0, {DW{1'b0}}};
    n_checks++;
    if (obs !== exp_v) $display("FAIL skid_empty: got %h, want %h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 65'h11;
    tick();
    out_ready = 1'b0;
    in_data   = 65'h22;
    tick();
    exp_v = {1'b0, 1'b1, 2'd2, 65'h11};
    n_checks++;
    if (obs !== exp_v) $display("FAIL flush_setup: got %h, want %h", obs, exp_v);
    else n_pass++;

    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = 65'h44;
    tick();
    exp_v = {1'b1, 1'b0, 2'd0, {DW{1'b0}}};
    n_checks++;
    if (obs !== exp_v) $display("FAIL flush_two: got %h, want %h", obs, exp_v);
    else n_pass++;

    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (obs !== exp_v) $display("FAIL flush_no44: got %h, want %h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_flush_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 65'h66;
    tick();
    flush = 1'b1;
    reset = 1'b1;
    in_data = 65'h77;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = {1'b1, 1'b0, 2'd0, {DW{1'b0}}};
      n_checks++;
      if (obs !== exp_v) $display("FAIL flush_reset[%0d]: got %h, want %h", i, obs, exp_v);
      else n_pass++;
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (obs !== exp_v) $display("FAIL flush_empty: got %h, want %h", obs, exp_v);
    else n_pass++;

    flush   = 1'b0;
    in_data = 65'h55;
    tick();
    exp_v = {1'b1, 1'b1, 2'd1, 65'h55};
    n_checks++;
    if (obs !== exp_v) $display("FAIL after_flush: got %h, want %h", obs, exp_v);
    else n_pass++;

    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    logic [DW-1:0] nop;
    logic          m_accept;
    logic          m_drain;
    int            errs;
    nop  = '0;
    errs = 0;
    q    = {};
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = {1'($urandom), 32'($urandom), 32'($urandom)};
      m_accept  = in_valid && (q.size() < 2);
      m_drain   = (q.size() > 0) && out_ready;
      if (m_drain) void'(q.pop_front());
      if (m_accept) q.push_back(in_data);
      tick();
      exp_v = {q.size() < 2, q.size() > 0, 2'(q.size()), (q.size() > 0) ? q[0] : nop};
      n_checks++;
      if (obs !== exp_v) begin
        errs++;
        if (errs <= 20) $display("FAIL random[%0d]: got %h, want %h", i, obs, exp_v);
      end else begin
        n_pass++;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush();
    test_flush_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
